nl_out_vc_allocator: RTL and testbench
======================================

# nl_out_vc_allocator

Per-output-port virtual-channel allocator sitting directly downstream of the output port's VC free pool. Each cycle it arbitrates among input VCs requesting this output port, binds the winner to one free downstream VC, and feeds the choice back to the free pool on `vc_allocated`. One instance per output port; grants go back to the input-port VC state machines.

## Interface
Parameters:
- `num_reqs`, 20, number of input VCs that may request this output port (ports x VCs).
- `num_vcs_global`, 4, VCs per link in the router; width of VC vectors.
- `num_vcs_local`, 4, VCs usable at this output port; indices >= this are never granted.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  num_reqs  input VC i requests a downstream VC on this port; held until granted.
- `vc_alloc_status`  in  num_vcs_global  from the free pool: VC v is free and its downstream FIFO is empty.
- `grant`  out  num_reqs  one-hot or zero, registered; requester that won this cycle.
- `grant_vc`  out  num_vcs_global  one-hot or zero, registered; downstream VC bound to `grant`.
- `grant_valid`  out  1  registered; equals OR of `grant`.
- `vc_allocated`  out  num_vcs_global  to the free pool; equals `grant_vc`.

## Operation
- Eligible requesters: `req & ~grant` (a requester granted in the current cycle is masked, since its `req` falls no earlier than the next cycle).
- Eligible VCs: `vc_alloc_status & ~grant_vc & local_mask`, where `local_mask[v] = (v < num_vcs_local)`. `grant_vc` is masked because the free pool clears its status bit one edge after `vc_allocated`.
- A grant is issued only if at least one eligible requester and one eligible VC exist; otherwise `grant`, `grant_vc`, `grant_valid` register to 0.
- Requester choice: round-robin. Search starts at `req_ptr`, ascending with wrap at num_reqs.
- VC choice: round-robin. Search starts at `vc_ptr`, ascending with wrap at num_vcs_global.
- Pointer update only on an issued grant: `req_ptr <= winner+1` mod num_reqs; `vc_ptr <= chosen_vc+1` mod num_vcs_global. With no grant, pointers hold.
- At most one allocation per cycle per output port.
- Pointer widths are $clog2 of the respective counts, minimum 1. Wrap is explicit compare-to-max, not power-of-two truncation.

## Timing
- Reset (`rst_n` low at an edge): `grant`, `grant_vc`, `vc_allocated` = 0; `grant_valid` = 0; `req_ptr` and `vc_ptr` = 0. A grant being formed is discarded; reset dominates.
- Latency: inputs sampled in cycle t → `grant`/`grant_vc`/`grant_valid`/`vc_allocated` valid throughout cycle t+1.
- Free pool clears the VC at edge t+2. The requester drops `req` at edge t+2, or re-requests for a new packet.
- Back-to-back grants in t+1 and t+2 are legal. They must differ in both requester and VC while the t+1 masks apply.
- A VC freed by a tail flit reappears in `vc_alloc_status` the cycle after the pool updates and is immediately eligible.
- Requester masking lasts exactly one cycle. A requester still asserting `req` in t+2 is eligible again in t+2.

## Structure
- Shared package: the existing `oh2bin` function; a `clog2_min1` helper/constant for pointer widths.
- Sub-module `nl_rr_arbiter` (parameter `n`): inputs `clk`, `rst_n`, `request[n]`, `update`; output one-hot `grant[n]`. It holds the internal pointer and advances it to winner+1 when `update` is high.
- Instantiated twice: requesters (n=num_reqs) and VCs (n=num_vcs_global). `update` = both arbiters have a winner. Top level holds the output registers and masks.

## Test plan
- Reset then idle: `req`=0, `vc_alloc_status`=4'b1111 → all outputs 0 for 10 cycles; pointers remain 0.
- Single request: `req[5]`=1 at t, status 4'b1111 → t+1: `grant[5]`=1, `grant_vc`=4'b0001, `vc_allocated`=4'b0001. If `req[5]` is held and status is unchanged, t+2 has no grant to 5; t+3 grants 5 with VC1.
- Fairness: `req[0]`, `req[3]`, `req[7]` held, status all 1 → successive grants to 0, 3, 7, 0 on VCs 0, 1, 2, 3.
- No free VC: `req[2]`=1, status 4'b0000 for 5 cycles → no grant. Status goes to 4'b0100 at cycle 6 → grant to 2 with `grant_vc`=4'b0100 at cycle 7.
- Stale status: status stuck at 4'b0001, `req[1]` and `req[4]`=1 → VC0 granted once, not in the following cycle. It is granted again two cycles later only because status never cleared (the bench models the pool to verify no double allocation).
- Local restriction, num_vcs_local=2: status 4'b1100 with a request → never granted. Reset mid-grant (`rst_n` low in t+1) → all outputs 0 next cycle.

Source files
------------

// File: rtl/nl_out_vc_allocator_pkg.sv
// ---------------------------------------------------------------------------
// nl_out_vc_allocator_pkg
//   Shared helpers for the output-port VC allocator slice.
//   - clog2_min1 : pointer width for an n-entry round-robin (never below 1).
//   - oh2bin     : one-hot to binary index, for vectors up to OH_MAX_W bits.
// ---------------------------------------------------------------------------
package nl_out_vc_allocator_pkg;

    localparam int OH_MAX_W = 64;
    localparam int OH_BIN_W = 6;

    // Width of a pointer that addresses n entries; a 1-entry space still needs a bit.
    function automatic int clog2_min1(input int n);
        int w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    // One-hot to binary. OR-ing the indices of set bits yields the index for a
    // one-hot input and zero for an all-zero input.
    function automatic logic [OH_BIN_W-1:0] oh2bin(input logic [OH_MAX_W-1:0] oh);
        logic [OH_BIN_W-1:0] b;
        b = {OH_BIN_W{1'b0}};
        for (int i = 0; i < OH_MAX_W; i++) begin
            if (oh[i]) begin
                b = b | OH_BIN_W'(i);
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/nl_out_vc_allocator_rr_arbiter.sv
// ---------------------------------------------------------------------------
// nl_rr_arbiter
//   Round-robin arbiter. The search starts at the internal pointer and runs
//   ascending with wrap; the pointer moves to winner+1 (wrapping at n-1) only
//   when update is high. The grant is combinational; the caller registers it.
//   Ports:
//     clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//     request[n] : competing requests
//     update     : commit the current winner and advance the pointer
//     grant[n]   : one-hot winner, zero when no request
// ---------------------------------------------------------------------------
module nl_rr_arbiter
    import nl_out_vc_allocator_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] request,
    input  logic         update,
    output logic [n-1:0] grant
);

    localparam int PW = clog2_min1(n);

    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       ptr_d;
    logic [n-1:0]        grant_s;
    logic                found_s;
    logic [OH_MAX_W-1:0] oh_ext_s;
    logic [OH_BIN_W-1:0] winner_bin_s;

    // Two passes: first from the pointer up to n-1, then from 0 below the pointer.
    always_comb begin
        grant_s = {n{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!found_s && request[i] && (i >= int'(ptr_q))) begin
                grant_s[i] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (!found_s && request[i] && (i < int'(ptr_q))) begin
                grant_s[i] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer: winner+1 with an explicit wrap at n-1, held without update.
    always_comb begin
        oh_ext_s          = {OH_MAX_W{1'b0}};
        oh_ext_s[n-1:0]   = grant_s;
        winner_bin_s      = oh2bin(oh_ext_s);
        ptr_d             = ptr_q;
        if (update) begin
            if (winner_bin_s == OH_BIN_W'(n - 1)) begin
                ptr_d = {PW{1'b0}};
            end else begin
                ptr_d = PW'(winner_bin_s + 6'd1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/nl_out_vc_allocator.sv
// ---------------------------------------------------------------------------
// nl_out_vc_allocator
//   Per-output-port VC allocator. Each cycle picks one requesting input VC and
//   one free downstream VC (both round-robin) and registers the binding.
//   Ports:
//     clk, rst_n       : clock, synchronous active-low reset
//     req              : input VCs requesting this output port
//     vc_alloc_status  : free-pool view of usable downstream VCs
//     grant            : registered one-hot winning requester
//     grant_vc         : registered one-hot downstream VC bound to grant
//     grant_valid      : registered OR of grant
//     vc_allocated     : to the free pool, same as grant_vc
// ---------------------------------------------------------------------------
module nl_out_vc_allocator
    import nl_out_vc_allocator_pkg::*;
#(
    parameter int num_reqs       = 20,
    parameter int num_vcs_global = 4,
    parameter int num_vcs_local  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [num_reqs-1:0]       req,
    input  logic [num_vcs_global-1:0] vc_alloc_status,
    output logic [num_reqs-1:0]       grant,
    output logic [num_vcs_global-1:0] grant_vc,
    output logic                      grant_valid,
    output logic [num_vcs_global-1:0] vc_allocated
);

    logic [num_reqs-1:0]       grant_q;
    logic [num_reqs-1:0]       grant_d;
    logic [num_vcs_global-1:0] grant_vc_q;
    logic [num_vcs_global-1:0] grant_vc_d;
    logic                      grant_valid_q;
    logic                      grant_valid_d;

    logic [num_vcs_global-1:0] local_mask_s;
    logic [num_reqs-1:0]       req_elig_s;
    logic [num_vcs_global-1:0] vc_elig_s;
    logic [num_reqs-1:0]       req_win_s;
    logic [num_vcs_global-1:0] vc_win_s;
    logic                      grant_en_s;

    // VCs at or above num_vcs_local do not exist at this port.
    always_comb begin
        local_mask_s = {num_vcs_global{1'b0}};
        for (int v = 0; v < num_vcs_global; v++) begin
            if (v < num_vcs_local) begin
                local_mask_s[v] = 1'b1;
            end else begin
                local_mask_s[v] = 1'b0;
            end
        end
    end

    // The requester just granted still shows req this cycle, and the pool
    // clears the VC one edge after vc_allocated, so both are masked for one cycle.
    always_comb begin
        req_elig_s = req & ~grant_q;
        vc_elig_s  = vc_alloc_status & ~grant_vc_q & local_mask_s;
    end

    nl_rr_arbiter #(
        .n (num_reqs)
    ) u_req_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .request (req_elig_s),
        .update  (grant_en_s),
        .grant   (req_win_s)
    );

    nl_rr_arbiter #(
        .n (num_vcs_global)
    ) u_vc_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .request (vc_elig_s),
        .update  (grant_en_s),
        .grant   (vc_win_s)
    );

    // A grant needs both a requester and a VC; otherwise outputs register to zero.
    always_comb begin
        grant_en_s    = (|req_win_s) & (|vc_win_s);
        grant_d       = {num_reqs{1'b0}};
        grant_vc_d    = {num_vcs_global{1'b0}};
        grant_valid_d = 1'b0;
        if (grant_en_s) begin
            grant_d       = req_win_s;
            grant_vc_d    = vc_win_s;
            grant_valid_d = 1'b1;
        end else begin
            grant_valid_d = 1'b0;
        end
    end

    // Output registers; reset dominates any grant being formed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q       <= {num_reqs{1'b0}};
            grant_vc_q    <= {num_vcs_global{1'b0}};
            grant_valid_q <= 1'b0;
        end else begin
            grant_q       <= grant_d;
            grant_vc_q    <= grant_vc_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant        = grant_q;
    assign grant_vc     = grant_vc_q;
    assign grant_valid  = grant_valid_q;
    assign vc_allocated = grant_vc_q;

endmodule

// File: tb/tb_nl_out_vc_allocator.sv
// ---------------------------------------------------------------------------
// tb_nl_out_vc_allocator
//   Directed scenarios plus randomized traffic against a reference model that
//   keeps the last grant and two rotating indices and searches with modulo
//   arithmetic. A second instance with num_vcs_local=2 covers VC restriction.
// ---------------------------------------------------------------------------
module tb_nl_out_vc_allocator;

    localparam int NR  = 20;
    localparam int NVG = 4;
    localparam int NVL = 4;

    logic           clk;
    logic           rst_n;
    logic [NR-1:0]  req;
    logic [NVG-1:0] status;
    logic [NR-1:0]  grant;
    logic [NVG-1:0] grant_vc;
    logic           grant_valid;
    logic [NVG-1:0] vc_allocated;

    logic [NR-1:0]  req2;
    logic [NVG-1:0] status2;
    logic [NR-1:0]  grant2;
    logic [NVG-1:0] grant_vc2;
    logic           grant_valid2;
    logic [NVG-1:0] vc_allocated2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model state
    int m_req_ptr, m_vc_ptr, m_gnt, m_vc;
    logic [NR-1:0]  exp_g;
    logic [NVG-1:0] exp_v;
    logic           exp_valid;
    logic [NR-1:0]  one_r  = 1;
    logic [NVG-1:0] one_v  = 1;

    nl_out_vc_allocator #(.num_reqs(NR), .num_vcs_global(NVG), .num_vcs_local(NVL)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .vc_alloc_status(status),
        .grant(grant), .grant_vc(grant_vc), .grant_valid(grant_valid),
        .vc_allocated(vc_allocated)
    );

    nl_out_vc_allocator #(.num_reqs(NR), .num_vcs_global(NVG), .num_vcs_local(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .vc_alloc_status(status2),
        .grant(grant2), .grant_vc(grant_vc2), .grant_valid(grant_valid2),
        .vc_allocated(vc_allocated2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one edge using the inputs the DUT is about to sample.
    task automatic model_edge();
        int wi, wv, idx;
        if (!rst_n) begin
            m_req_ptr = 0; m_vc_ptr = 0; m_gnt = -1; m_vc = -1;
        end else begin
            wi = -1; wv = -1;
            for (int k = 0; k < NR; k++) begin
                idx = (m_req_ptr + k) % NR;
                if (wi < 0 && req[idx] && idx != m_gnt) wi = idx;
            end
            for (int k = 0; k < NVG; k++) begin
                idx = (m_vc_ptr + k) % NVG;
                if (wv < 0 && status[idx] && idx != m_vc && idx < NVL) wv = idx;
            end
            if (wi >= 0 && wv >= 0) begin
                m_gnt = wi; m_vc = wv;
                m_req_ptr = (wi + 1) % NR;
                m_vc_ptr  = (wv + 1) % NVG;
            end else begin
                m_gnt = -1; m_vc = -1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        exp_g = '0; exp_v = '0; exp_valid = 1'b0;
        if (m_gnt >= 0) begin
            exp_g = one_r << m_gnt;
            exp_v = one_v << m_vc;
            exp_valid = 1'b1;
        end
        cyc++;
    endtask

    task automatic apply_reset();
        req = '0; status = '0; req2 = '0; status2 = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (grant !== '0 || grant_vc !== '0 || grant_valid !== 1'b0 || vc_allocated !== '0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%h vc=%h valid=%b alloc=%h expected all zero",
                     grant, grant_vc, grant_valid, vc_allocated);
        end
        status = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (grant !== '0 || grant_vc !== '0 || grant_valid !== 1'b0 || vc_allocated !== '0) begin
                n_fail++;
                $display("FAIL idle cyc%0d: grant=%h vc=%h valid=%b expected zero", i, grant, grant_vc, grant_valid);
            end
        end
    endtask

    task automatic test_single();
        logic [NVG-1:0] want_vc [3];
        logic           want_ok [3];
        want_vc = '{4'b0001, 4'b0000, 4'b0010};
        want_ok = '{1'b1, 1'b0, 1'b1};
        apply_reset();
        status = 4'b1111;
        req = one_r << 5;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (grant !== (want_ok[i] ? (one_r << 5) : '0) || grant_vc !== want_vc[i]
                || vc_allocated !== want_vc[i] || grant_valid !== want_ok[i]) begin
                n_fail++;
                $display("FAIL single step%0d: grant=%h vc=%b alloc=%b valid=%b expected vc=%b valid=%b",
                         i, grant, grant_vc, vc_allocated, grant_valid, want_vc[i], want_ok[i]);
            end
        end
        req = '0;
    endtask

    task automatic test_fairness();
        int want_r [4];
        want_r = '{0, 3, 7, 0};
        apply_reset();
        status = 4'b1111;
        req = (one_r << 0) | (one_r << 3) | (one_r << 7);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (grant !== (one_r << want_r[i]) || grant_vc !== (one_v << i) || grant_valid !== 1'b1
                || grant !== exp_g || grant_vc !== exp_v) begin
                n_fail++;
                $display("FAIL fairness step%0d: grant=%h vc=%b expected grant=%h vc=%b",
                         i, grant, grant_vc, one_r << want_r[i], one_v << i);
            end
        end
        req = '0;
    endtask

    task automatic test_no_free_vc();
        apply_reset();
        req = one_r << 2;
        status = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (grant !== '0 || grant_valid !== 1'b0 || grant_vc !== '0) begin
                n_fail++;
                $display("FAIL no_free_vc cyc%0d: grant=%h vc=%b valid=%b expected zero", i, grant, grant_vc, grant_valid);
            end
        end
        status = 4'b0100;
        tick();
        n_cmp++;
        if (grant !== (one_r << 2) || grant_vc !== 4'b0100 || vc_allocated !== 4'b0100 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL vc_freed: grant=%h vc=%b valid=%b expected grant=%h vc=0100",
                     grant, grant_vc, grant_valid, one_r << 2);
        end
        req = '0;
    endtask

    task automatic test_stale_status();
        int want_r [3];
        logic want_ok [3];
        want_r  = '{1, 0, 4};
        want_ok = '{1'b1, 1'b0, 1'b1};
        apply_reset();
        status = 4'b0001;
        req = (one_r << 1) | (one_r << 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (grant_valid !== want_ok[i] || grant !== (want_ok[i] ? (one_r << want_r[i]) : '0)
                || grant_vc !== (want_ok[i] ? 4'b0001 : 4'b0000) || grant !== exp_g) begin
                n_fail++;
                $display("FAIL stale step%0d: grant=%h vc=%b valid=%b expected valid=%b", i, grant, grant_vc, grant_valid, want_ok[i]);
            end
        end
        req = '0;
    endtask

    task automatic test_local_restriction();
        apply_reset();
        req2 = one_r << 6;
        status2 = 4'b1100;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (grant2 !== '0 || grant_vc2 !== '0 || grant_valid2 !== 1'b0) begin
                n_fail++;
                $display("FAIL local_mask cyc%0d: grant=%h vc=%b valid=%b expected zero", i, grant2, grant_vc2, grant_valid2);
            end
        end
        status2 = 4'b1110;
        tick();
        n_cmp++;
        if (grant2 !== (one_r << 6) || grant_vc2 !== 4'b0010 || vc_allocated2 !== 4'b0010 || grant_valid2 !== 1'b1) begin
            n_fail++;
            $display("FAIL local_grant: grant=%h vc=%b valid=%b expected vc=0010", grant2, grant_vc2, grant_valid2);
        end
        req2 = '0; status2 = '0;
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        status = 4'b1111;
        req = one_r << 5;
        tick();
        n_cmp++;
        if (grant !== (one_r << 5) || grant_vc !== 4'b0001) begin
            n_fail++;
            $display("FAIL pre_reset_grant: grant=%h vc=%b expected grant=%h vc=0001", grant, grant_vc, one_r << 5);
        end
        req = (one_r << 5) | (one_r << 3);
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (grant !== '0 || grant_vc !== '0 || grant_valid !== 1'b0 || vc_allocated !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_grant: grant=%h vc=%b valid=%b expected zero", grant, grant_vc, grant_valid);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (grant !== (one_r << 3) || grant_vc !== 4'b0001 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ptrs: grant=%h vc=%b expected grant=%h vc=0001", grant, grant_vc, one_r << 3);
        end
        req = '0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            req    = NR'($urandom) & NR'($urandom);
            status = NVG'($urandom_range(0, 15));
            tick();
            n_cmp++;
            if (grant !== exp_g || grant_vc !== exp_v || grant_valid !== exp_valid || vc_allocated !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc%0d: grant=%h vc=%b valid=%b alloc=%b expected grant=%h vc=%b valid=%b",
                         i, grant, grant_vc, grant_valid, vc_allocated, exp_g, exp_v, exp_valid);
            end
        end
        req = '0; status = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; status = '0; req2 = '0; status2 = '0;
        m_req_ptr = 0; m_vc_ptr = 0; m_gnt = -1; m_vc = -1;
        test_reset();
        test_single();
        test_fairness();
        test_no_free_vc();
        test_stale_status();
        test_local_restriction();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
